// File: rtl/vga_sync.sv
// VGA raster timing generator: x/y scan counters, visible-area enable, and a
// two-stage pipeline that delay-matches hsync/vsync to the registered pixel colour.
module vga_sync #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        en,
    output logic        frame_start,
    input  logic [5:0]  color,
    output logic [1:0]  vga_r,
    output logic [1:0]  vga_g,
    output logic [1:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
    localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        en_q, en_d;
    logic        fs_q, fs_d;
    logic        hs_raw, vs_raw;
    logic        en_d1_q, hs_d1_q, vs_d1_q;
    logic [5:0]  rgb_q;
    logic        hsync_q, vsync_q;

    always_comb begin
        x_d = x_q + 11'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = 11'd0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
        // en/frame_start come from the next-state counters so they line up with x/y.
        en_d   = (x_d < H_VIS_C) && (y_d < V_VIS_C);
        fs_d   = (x_d == 11'd0) && (y_d == 10'd0);
        hs_raw = (x_q >= HS_START) && (x_q < HS_END);
        vs_raw = (y_q >= VS_START) && (y_q < VS_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            en_q    <= 1'b0;
            fs_q    <= 1'b0;
            en_d1_q <= 1'b0;
            hs_d1_q <= 1'b0;
            vs_d1_q <= 1'b0;
            rgb_q   <= 6'd0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= en_d;
            fs_q    <= fs_d;
            en_d1_q <= en_q;
            hs_d1_q <= hs_raw;
            vs_d1_q <= vs_raw;
            // Generators register colour, so it pairs with the enable one stage later.
            rgb_q   <= en_d1_q ? color : 6'd0;
            hsync_q <= hs_d1_q ~^ HS_POL;
            vsync_q <= vs_d1_q ~^ VS_POL;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign en          = en_q;
    assign frame_start = fs_q;
    assign vga_r       = rgb_q[5:4];
    assign vga_g       = rgb_q[3:2];
    assign vga_b       = rgb_q[1:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: small-raster instances (both sync polarities) checked against
// a position-arithmetic model, plus a default-timing instance checked around reset.
module tb_vga_sync;
    localparam int HV = 16, HFP = 3, HSW = 4, HBP = 5;
    localparam int VV = 6, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HV + HFP + HSW + HBP;
    localparam int VT = VV + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] color = 6'd0;

    logic [10:0] a_x, b_x, d_x;
    logic [9:0]  a_y, b_y, d_y;
    logic        a_en, b_en, d_en, a_fs, b_fs, d_fs;
    logic [1:0]  a_r, a_g, a_b, b_r, b_g, b_b, d_r, d_g, d_b;
    logic        a_hs, b_hs, d_hs, a_vs, b_vs, d_vs;

    vga_sync #(.H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
               .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
               .HS_POL(1'b1), .VS_POL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .x(a_x), .y(a_y), .en(a_en), .frame_start(a_fs),
        .color(color), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .hsync(a_hs), .vsync(a_vs));

    vga_sync #(.H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
               .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
               .HS_POL(1'b0), .VS_POL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .x(b_x), .y(b_y), .en(b_en), .frame_start(b_fs),
        .color(color), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .hsync(b_hs), .vsync(b_vs));

    vga_sync dut_d (
        .clk(clk), .rst(rst), .x(d_x), .y(d_y), .en(d_en), .frame_start(d_fs),
        .color(color), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .hsync(d_hs), .vsync(d_vs));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n = 0;

    typedef struct {
        int n; int x; int y; bit en; bit fs; logic [5:0] rgb; bit hs; bit vs;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    // Reference: raster position is just (edges since release - 1) mod frame;
    // pins show the position from two edges earlier.
    task automatic check_model(input logic [5:0] c);
        int p, ex, ey, q, qx, qy;
        logic ergb, ehs, evs;
        logic [5:0] rgb;
        p  = (n - 1) % FRAME;
        ex = p % HT;
        ey = p / HT;
        if (n < 3) begin
            rgb = 6'd0; ehs = 1'b0; evs = 1'b0;
        end else begin
            q  = (n - 3) % FRAME;
            qx = q % HT;
            qy = q / HT;
            ergb = (qx < HV) && (qy < VV);
            rgb  = ergb ? c : 6'd0;
            ehs  = (qx >= HV + HFP) && (qx < HV + HFP + HSW);
            evs  = (qy >= VV + VFP) && (qy < VV + VFP + VSW);
        end
        chk("x", 32'(a_x), 32'(ex));
        chk("y", 32'(a_y), 32'(ey));
        chk("en", 32'(a_en), 32'((ex < HV) && (ey < VV)));
        chk("frame_start", 32'(a_fs), 32'(p == 0));
        chk("rgb", 32'({a_r, a_g, a_b}), 32'(rgb));
        chk("hsync", 32'(a_hs), 32'(ehs));
        chk("vsync", 32'(a_vs), 32'(evs));
        chk("rgb_pol0", 32'({b_r, b_g, b_b}), 32'(rgb));
        chk("hsync_pol0", 32'(b_hs), 32'(!ehs));
        chk("vsync_pol0", 32'(b_vs), 32'(!evs));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(a_x), 32'(HT - 1));
        chk({tag, "_y"}, 32'(a_y), 32'(VT - 1));
        chk({tag, "_en"}, 32'(a_en), 0);
        chk({tag, "_fs"}, 32'(a_fs), 0);
        chk({tag, "_rgb"}, 32'({a_r, a_g, a_b}), 0);
        chk({tag, "_hs"}, 32'(a_hs), 0);
        chk({tag, "_vs"}, 32'(a_vs), 0);
        chk({tag, "_hs_pol0"}, 32'(b_hs), 1);
        chk({tag, "_vs_pol0"}, 32'(b_vs), 1);
        chk({tag, "_dx"}, 32'(d_x), 1039);
        chk({tag, "_dy"}, 32'(d_y), 665);
        chk({tag, "_den"}, 32'(d_en), 0);
        chk({tag, "_dhs"}, 32'(d_hs), 0);
        chk({tag, "_dvs"}, 32'(d_vs), 0);
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b0;
        #1 check_reset_vals("rst_async");
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1 check_reset_vals("rst_hold");
        end
        rst = 1'b1;
        n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti;
        logic [5:0] cur;
        tbl = '{
            '{1,   0,  0, 1, 1, 6'd0,  0, 0},
            '{2,   1,  0, 1, 0, 6'd0,  0, 0},
            '{3,   2,  0, 1, 0, 6'd39, 0, 0},
            '{17,  16, 0, 0, 0, 6'd39, 0, 0},
            '{18,  17, 0, 0, 0, 6'd39, 0, 0},
            '{19,  18, 0, 0, 0, 6'd0,  0, 0},
            '{21,  20, 0, 0, 0, 6'd0,  0, 0},
            '{22,  21, 0, 0, 0, 6'd0,  1, 0},
            '{25,  24, 0, 0, 0, 6'd0,  1, 0},
            '{26,  25, 0, 0, 0, 6'd0,  0, 0},
            '{29,  0,  1, 1, 0, 6'd0,  0, 0},
            '{31,  2,  1, 1, 0, 6'd39, 0, 0},
            '{226, 1,  8, 0, 0, 6'd0,  0, 0},
            '{227, 2,  8, 0, 0, 6'd0,  0, 1},
            '{282, 1, 10, 0, 0, 6'd0,  0, 1},
            '{283, 2, 10, 0, 0, 6'd0,  0, 0},
            '{365, 0,  0, 1, 1, 6'd0,  0, 0},
            '{366, 1,  0, 1, 0, 6'd0,  0, 0}
        };
        color = 6'b100111;

        // Power-on reset held 5 cycles, released away from the clock edge.
        @(posedge clk);
        #1 hold_reset(5);

        ti = 0;
        for (int k = 0; k < 370; k++) begin
            @(posedge clk);
            #1 n++;
            if (n == 1) begin
                chk("dflt_x0", 32'(d_x), 0);
                chk("dflt_y0", 32'(d_y), 0);
                chk("dflt_en0", 32'(d_en), 1);
                chk("dflt_fs0", 32'(d_fs), 1);
            end
            if (n == 2) begin
                chk("dflt_x1", 32'(d_x), 1);
                chk("dflt_fs1", 32'(d_fs), 0);
            end
            if (ti < 18 && tbl[ti].n == n) begin
                chk("tbl_x", 32'(a_x), 32'(tbl[ti].x));
                chk("tbl_y", 32'(a_y), 32'(tbl[ti].y));
                chk("tbl_en", 32'(a_en), 32'(tbl[ti].en));
                chk("tbl_fs", 32'(a_fs), 32'(tbl[ti].fs));
                chk("tbl_r", 32'(a_r), 32'(tbl[ti].rgb[5:4]));
                chk("tbl_g", 32'(a_g), 32'(tbl[ti].rgb[3:2]));
                chk("tbl_b", 32'(a_b), 32'(tbl[ti].rgb[1:0]));
                chk("tbl_hs", 32'(a_hs), 32'(tbl[ti].hs));
                chk("tbl_vs", 32'(a_vs), 32'(tbl[ti].vs));
                chk("tbl_hs_pol0", 32'(b_hs), 32'(!tbl[ti].hs));
                chk("tbl_vs_pol0", 32'(b_vs), 32'(!tbl[ti].vs));
                ti++;
            end
        end
        chk("tbl_all_applied", 32'(ti), 18);

        // Run to (x=22, y=3) of the second frame, mid hsync pulse, then reset there.
        while (n < 471) begin
            @(posedge clk);
            #1 n++;
            check_model(6'b100111);
        end
        chk("pre_rst_x", 32'(a_x), 22);
        chk("pre_rst_y", 32'(a_y), 3);
        chk("pre_rst_hs", 32'(a_hs), 1);
        hold_reset(1);

        // Random colour over two full frames after the mid-frame reset.
        cur = 6'd0;
        for (int k = 0; k < 2 * FRAME + 60; k++) begin
            color = 6'($urandom_range(0, 63));
            cur = color;
            @(posedge clk);
            #1 n++;
            check_model(cur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
